// File: rtl/axi_interconnect_fifogen_pkg.sv
// Shared fifogen helpers: Gray-code direction tags and bin<->gray conversion functions.
// Inputs are zero-extended to GRAY_MAXW bits, so callers truncate the result back to their own width.
package axi_interconnect_fifogen_pkg;

  localparam logic GRAY_ENC = 1'b0;
  localparam logic GRAY_DEC = 1'b1;
  localparam int unsigned GRAY_MAXW = 64;

  function automatic logic [GRAY_MAXW-1:0] f_bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; leading zeros from zero-extension leave the result unchanged.
  function automatic logic [GRAY_MAXW-1:0] f_gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    logic                 acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAXW - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/axi_interconnect_fifogen_pipe_stage.sv
// One valid/ready register slice. The load enable is computed by the parent from the whole valid chain.
module axi_interconnect_fifogen_pipe_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         sclr,
  input  logic         ld,
  input  logic         up_vld,
  input  logic [W-1:0] up_data,
  output logic         dn_vld,
  output logic [W-1:0] dn_data
);

  logic         vld_d, vld_q;
  logic [W-1:0] data_d, data_q;

  // Data only moves when a valid word is loaded; an empty stage keeps its stale data.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (sclr) begin
      vld_d = 1'b0;
    end else if (ld) begin
      vld_d = up_vld;
      if (up_vld) data_d = up_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign dn_vld  = vld_q;
  assign dn_data = data_q;

endmodule

// File: rtl/axi_interconnect_fifogen_gray_codec.sv
// Multi-channel binary<->Gray converter followed by a PIPE_LINE-deep valid/ready pipeline.
// Conversion happens ahead of stage 1; later stages only delay the result.
module axi_interconnect_fifogen_gray_codec
  import axi_interconnect_fifogen_pkg::*;
#(
  parameter int unsigned    CH        = 2,
  parameter int unsigned    DW        = 16,
  parameter int unsigned    PIPE_LINE = 2,
  parameter logic [CH-1:0]  MODE_MASK = '0
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [CH*DW-1:0] idata,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [CH*DW-1:0] odata
);

  localparam int unsigned W = CH * DW;

  logic [W-1:0] conv_c;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    if (MODE_MASK[c] == GRAY_DEC) begin : g_dec
      assign conv_c[c*DW +: DW] = DW'(f_gray2bin(GRAY_MAXW'(idata[c*DW +: DW])));
    end else begin : g_enc
      assign conv_c[c*DW +: DW] = DW'(f_bin2gray(GRAY_MAXW'(idata[c*DW +: DW])));
    end
  end

  if (PIPE_LINE == 0) begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk_sys, rst_n, sclr};
    assign odata = conv_c;
    assign o_vld = i_vld;
    assign i_rdy = o_rdy;
  end else begin : g_pipe
    logic [PIPE_LINE:0] vld_s;
    logic [PIPE_LINE:1] ld_c;
    logic [W-1:0]       data_s [PIPE_LINE+1];

    assign vld_s[0]  = i_vld;
    assign data_s[0] = conv_c;

    // Stage k loads when it is empty or everything downstream of it moves this cycle.
    always_comb begin
      logic nxt;
      ld_c = '0;
      nxt  = o_rdy;
      for (int k = PIPE_LINE; k >= 1; k--) begin
        ld_c[k] = !vld_s[k] || nxt;
        nxt     = ld_c[k];
      end
    end

    for (genvar k = 1; k <= PIPE_LINE; k++) begin : g_stage
      axi_interconnect_fifogen_pipe_stage #(.W(W)) u_stage (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .sclr    (sclr),
        .ld      (ld_c[k]),
        .up_vld  (vld_s[k-1]),
        .up_data (data_s[k-1]),
        .dn_vld  (vld_s[k]),
        .dn_data (data_s[k])
      );
    end

    assign i_rdy = ld_c[1] & ~sclr;
    assign o_vld = vld_s[PIPE_LINE];
    assign odata = data_s[PIPE_LINE];
  end

endmodule

// File: tb/tb_axi_interconnect_fifogen_gray_codec.sv
// Scoreboard bench for the Gray codec: a 4-bit/2-stage, a 16-bit/3-stage and a 16-bit combinational instance.
module tb_axi_interconnect_fifogen_gray_codec;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  logic       a_sclr, a_i_vld, a_i_rdy, a_o_vld, a_o_rdy;
  logic [7:0] a_idata, a_odata;
  logic        b_sclr, b_i_vld, b_i_rdy, b_o_vld, b_o_rdy;
  logic [31:0] b_idata, b_odata;
  logic        c_sclr, c_i_vld, c_i_rdy, c_o_vld, c_o_rdy;
  logic [31:0] c_idata, c_odata;

  axi_interconnect_fifogen_gray_codec #(.CH(2), .DW(4), .PIPE_LINE(2), .MODE_MASK(2'b10)) u_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .sclr(a_sclr), .i_vld(a_i_vld), .i_rdy(a_i_rdy),
    .idata(a_idata), .o_vld(a_o_vld), .o_rdy(a_o_rdy), .odata(a_odata));

  axi_interconnect_fifogen_gray_codec #(.CH(2), .DW(16), .PIPE_LINE(3), .MODE_MASK(2'b10)) u_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .sclr(b_sclr), .i_vld(b_i_vld), .i_rdy(b_i_rdy),
    .idata(b_idata), .o_vld(b_o_vld), .o_rdy(b_o_rdy), .odata(b_odata));

  axi_interconnect_fifogen_gray_codec #(.CH(2), .DW(16), .PIPE_LINE(0), .MODE_MASK(2'b10)) u_c (
    .clk_sys(clk_sys), .rst_n(rst_n), .sclr(c_sclr), .i_vld(c_i_vld), .i_rdy(c_i_rdy),
    .idata(c_idata), .o_vld(c_o_vld), .o_rdy(c_o_rdy), .odata(c_odata));

  logic [7:0]  a_q[$];
  logic [31:0] b_q[$];
  int          cyc = 0;
  logic        sweep = 1'b0;
  logic        have_prev = 1'b0;
  logic [15:0] prev_g;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_b2g(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] m_g2b(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Monitors: pop the oldest expected word whenever an output transfer is presented.
  always @(negedge clk_sys) begin
    if (rst_n && a_o_vld && a_o_rdy) begin
      if (a_q.size() == 0) chk("a_unexpected_word", {56'd0, a_odata}, 64'hDEAD);
      else chk("a_data", {56'd0, a_odata}, {56'd0, a_q.pop_front()});
    end
  end

  always @(negedge clk_sys) begin
    if (rst_n && b_o_vld && b_o_rdy) begin
      if (b_q.size() == 0) chk("b_unexpected_word", {32'd0, b_odata}, 64'hDEAD);
      else chk("b_data", {32'd0, b_odata}, {32'd0, b_q.pop_front()});
      if (sweep) begin
        if (have_prev) chk("b_gray_step_bits", 64'($countones(prev_g ^ b_odata[15:0])), 64'd1);
        prev_g    = b_odata[15:0];
        have_prev = 1'b1;
      end
    end
  end

  task automatic send_a(input logic [7:0] d, input logic [7:0] e);
    logic acc = 1'b0;
    int   t   = 0;
    a_i_vld = 1'b1;
    a_idata = d;
    while (!acc && t < 100) begin
      @(negedge clk_sys);
      acc = a_i_rdy;
      if (acc) a_q.push_back(e);
      @(posedge clk_sys);
      #1;
      t++;
    end
    if (!acc) chk("a_accept_timeout", 64'd0, 64'd1);
    a_i_vld = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic [31:0] e);
    logic acc = 1'b0;
    int   t   = 0;
    b_i_vld = 1'b1;
    b_idata = d;
    while (!acc && t < 100) begin
      @(negedge clk_sys);
      acc = b_i_rdy;
      if (acc) b_q.push_back(e);
      @(posedge clk_sys);
      #1;
      t++;
    end
    if (!acc) chk("b_accept_timeout", 64'd0, 64'd1);
    b_i_vld = 1'b0;
  endtask

  function automatic logic [31:0] b_exp(input logic [31:0] d);
    return {m_g2b(d[31:16]), m_b2g(d[15:0])};
  endfunction

  task automatic drain_b();
    int t = 0;
    while (b_q.size() != 0 && t < 60) begin
      @(posedge clk_sys);
      t++;
    end
    #1;
    chk("b_drain_empty", 64'(b_q.size()), 64'd0);
  endtask

  // Called right after the accept edge: o_vld must rise exactly three edges after the accept.
  task automatic lat_b(input string nm);
    repeat (2) begin
      @(negedge clk_sys);
      chk({nm, "_early_vld"}, 64'(b_o_vld), 64'd0);
      @(posedge clk_sys);
      #1;
    end
    @(negedge clk_sys);
    chk({nm, "_vld"}, 64'(b_o_vld), 64'd1);
  endtask

  initial begin
    int t0;
    logic [31:0] cap;
    a_sclr = 0; a_i_vld = 0; a_o_rdy = 1; a_idata = '0;
    b_sclr = 0; b_i_vld = 0; b_o_rdy = 1; b_idata = '0;
    c_sclr = 0; c_i_vld = 0; c_o_rdy = 1; c_idata = '0;

    repeat (2) @(negedge clk_sys);
    chk("a_rst_vld", 64'(a_o_vld), 64'd0);
    chk("a_rst_data", 64'(a_odata), 64'd0);
    chk("b_rst_vld", 64'(b_o_vld), 64'd0);
    chk("b_rst_data", 64'(b_odata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("b_idle_rdy", 64'(b_i_rdy), 64'd1);

    // Mixed channels, 2-stage latency.
    send_a(8'b0101_0110, 8'b0110_0101);
    @(negedge clk_sys);
    chk("a_early_vld", 64'(a_o_vld), 64'd0);
    @(posedge clk_sys);
    #1;
    @(negedge clk_sys);
    chk("a_lat_vld", 64'(a_o_vld), 64'd1);
    chk("a_lat_data", 64'(a_odata), 64'h65);
    @(posedge clk_sys);
    #1;
    send_a(8'b1000_1111, 8'b1111_1000);
    send_a(8'b0011_0001, 8'b0010_0001);
    repeat (4) @(posedge clk_sys);
    #1;
    chk("a_drain_empty", 64'(a_q.size()), 64'd0);

    // Hand-computed decode vectors on the upper channel.
    send_b({16'hFFFF, 16'h0000}, {16'hAAAA, 16'h0000});
    send_b({16'hC000, 16'h0006}, {16'h8000, 16'h0005});
    send_b({16'h0001, 16'hFFFF}, {16'h0001, 16'h8000});
    drain_b();

    // Full sweep including the wrap back to zero.
    sweep     = 1'b1;
    have_prev = 1'b0;
    t0 = cyc;
    for (int n = 0; n <= 65536; n++) begin
      logic [15:0] v;
      v = 16'(n);
      send_b({v, v}, {m_g2b(v), m_b2g(v)});
    end
    chk("b_sweep_cycles", 64'(cyc - t0), 64'd65537);
    drain_b();
    sweep = 1'b0;

    // Backpressure during a stream.
    fork
      begin
        for (int i = 0; i < 12; i++) send_b(32'h0101_0000 * 32'(i) + 32'(i), b_exp(32'h0101_0000 * 32'(i) + 32'(i)));
      end
      begin
        repeat (4) @(posedge clk_sys);
        #1;
        b_o_rdy = 1'b0;
        @(negedge clk_sys);
        cap = b_odata;
        chk("b_stall_vld", 64'(b_o_vld), 64'd1);
        repeat (5) begin
          @(negedge clk_sys);
          chk("b_stall_data_stable", 64'(b_odata), 64'(cap));
          chk("b_stall_vld_stable", 64'(b_o_vld), 64'd1);
        end
        chk("b_stall_full_rdy", 64'(b_i_rdy), 64'd0);
        @(posedge clk_sys);
        #1;
        b_o_rdy = 1'b1;
      end
    join
    drain_b();

    // Synchronous clear with two words in flight.
    b_o_rdy = 1'b0;
    send_b(32'h1111_2222, b_exp(32'h1111_2222));
    send_b(32'h3333_4444, b_exp(32'h3333_4444));
    b_sclr = 1'b1;
    b_i_vld = 1'b1;
    b_idata = 32'h5555_6666;
    b_q.delete();
    @(negedge clk_sys);
    chk("b_sclr_rdy", 64'(b_i_rdy), 64'd0);
    @(posedge clk_sys);
    #1;
    b_sclr = 1'b0;
    b_i_vld = 1'b0;
    b_o_rdy = 1'b1;
    @(negedge clk_sys);
    chk("b_sclr_vld", 64'(b_o_vld), 64'd0);
    repeat (4) @(posedge clk_sys);
    #1;
    chk("b_sclr_quiet", 64'(b_o_vld), 64'd0);
    send_b(32'h0000_0007, b_exp(32'h0000_0007));
    lat_b("b_post_sclr");
    drain_b();

    // Asynchronous reset between edges with words in flight.
    send_b(32'h1234_5678, b_exp(32'h1234_5678));
    send_b(32'h9ABC_DEF0, b_exp(32'h9ABC_DEF0));
    send_b(32'h0F0F_F0F0, b_exp(32'h0F0F_F0F0));
    #2;
    chk("b_pre_rst_vld", 64'(b_o_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("b_async_rst_vld", 64'(b_o_vld), 64'd0);
    chk("b_async_rst_data", 64'(b_odata), 64'd0);
    b_q.delete();
    #12;
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;
    send_b(32'hC000_0002, 32'h8000_0003);
    lat_b("b_post_rst");
    drain_b();

    // Combinational instance: result in the same cycle, sclr ignored.
    c_i_vld = 1'b1;
    c_idata = {16'hFFFF, 16'h0006};
    #1;
    chk("c_dec_ffff", 64'(c_odata), 64'hAAAA_0005);
    chk("c_vld_follow", 64'(c_o_vld), 64'd1);
    c_idata = {16'hC000, 16'hFFFF};
    c_sclr  = 1'b1;
    #1;
    chk("c_dec_c000", 64'(c_odata), 64'h8000_8000);
    chk("c_sclr_no_effect", 64'(c_o_vld), 64'd1);
    c_idata = {16'h0001, 16'h8000};
    c_o_rdy = 1'b0;
    c_i_vld = 1'b0;
    #1;
    chk("c_dec_0001", 64'(c_odata), 64'h0001_C000);
    chk("c_rdy_follow", 64'(c_i_rdy), 64'd0);
    chk("c_vld_low", 64'(c_o_vld), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
